// File: rtl/dense_layer_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dense_layer_mac_sequencer_if
// Description : Input-vector, weight-ROM and result handshake bundle for the
//               dense-layer MAC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dense_layer_mac_sequencer_if #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 5,
    parameter int WIDTH = 15
) ();
    localparam int c_addr_w = $clog2(N_IN);

    logic                     in_valid;
    logic                     in_ready;
    logic [N_IN*WIDTH-1:0]    in_data;
    logic [c_addr_w-1:0]      w_addr;
    logic [N_OUT*WIDTH-1:0]   w_row;
    logic [N_OUT*WIDTH-1:0]   bias;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_OUT*WIDTH-1:0]   out_data;
    logic [N_OUT-1:0]         out_sat;
    logic                     busy;

    modport master (
        output in_valid, in_data, w_row, bias, out_ready,
        input  in_ready, w_addr, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_data, w_row, bias, out_ready,
        output in_ready, w_addr, out_valid, out_data, out_sat, busy
    );
endinterface
`default_nettype wire

// File: rtl/dense_layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dense_layer_mac_sequencer
// Description : Time-multiplexed dense layer: one ROM row per cycle into N_OUT
//               parallel MACs, then bias, round-half-up and saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_layer_mac_sequencer #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 5,
    parameter int WIDTH = 15,
    parameter int NFRAC = 7,
    parameter int ACC_W = 2*WIDTH + $clog2(N_IN)
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    dense_layer_mac_sequencer_if.slave  bus
);
    localparam int c_addr_w = $clog2(N_IN);
    localparam logic [c_addr_w-1:0] c_k_last = c_addr_w'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] c_round =
        {{(ACC_W-NFRAC){1'b0}}, 1'b1, {(NFRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [c_addr_w-1:0]         k_q, k_d;
    logic [c_addr_w-1:0]         w_addr_q, w_addr_d;
    logic [N_IN*WIDTH-1:0]       x_q, x_d;
    logic signed [ACC_W-1:0]     acc_q [N_OUT];
    logic signed [ACC_W-1:0]     acc_d [N_OUT];
    logic                        out_valid_q, out_valid_d;
    logic [N_OUT*WIDTH-1:0]      out_data_q, out_data_d;
    logic [N_OUT-1:0]            out_sat_q, out_sat_d;

    logic signed [WIDTH-1:0]     x_k;
    logic signed [ACC_W-1:0]     acc_mac    [N_OUT];
    logic signed [ACC_W-1:0]     acc_biased [N_OUT];
    logic [N_OUT*WIDTH-1:0]      y_flat;
    logic [N_OUT-1:0]            sat_flat;

    assign x_k = x_q[k_q*WIDTH +: WIDTH];

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        logic signed [WIDTH-1:0]   w_j;
        logic signed [WIDTH-1:0]   b_j;
        logic signed [2*WIDTH-1:0] prod;
        logic signed [ACC_W-1:0]   prod_ext;
        logic signed [ACC_W-1:0]   bias_ext;
        logic signed [ACC_W-1:0]   rounded;
        logic signed [ACC_W-1:0]   shifted;
        logic                      over;
        logic                      under;

        assign w_j      = bus.w_row[j*WIDTH +: WIDTH];
        assign b_j      = bus.bias[j*WIDTH +: WIDTH];
        assign prod     = x_k * w_j;
        assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        // Bias is aligned to the product's 2*NFRAC fractional bits.
        assign bias_ext = {{(ACC_W-WIDTH-NFRAC){b_j[WIDTH-1]}}, b_j, {NFRAC{1'b0}}};

        assign acc_mac[j]    = acc_q[j] + prod_ext;
        assign acc_biased[j] = acc_q[j] + bias_ext;
        assign rounded       = acc_biased[j] + c_round;
        assign shifted       = rounded >>> NFRAC;
        assign over          = shifted > c_sat_max;
        assign under         = shifted < c_sat_min;

        assign sat_flat[j] = over | under;
        assign y_flat[j*WIDTH +: WIDTH] = over  ? c_sat_max[WIDTH-1:0] :
                                          under ? c_sat_min[WIDTH-1:0] :
                                                  shifted[WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        w_addr_d    = w_addr_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        for (int j = 0; j < N_OUT; j++) begin
            acc_d[j] = acc_q[j];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d      = bus.in_data;
                    k_d      = '0;
                    w_addr_d = '0;
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_d[j] = '0;
                    end
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                w_addr_d = w_addr_q + c_addr_w'(1);
                state_d  = S_MAC;
            end
            S_MAC: begin
                // w_addr runs one row ahead of k to hide the ROM read latency.
                for (int j = 0; j < N_OUT; j++) begin
                    acc_d[j] = acc_mac[j];
                end
                k_d      = k_q + c_addr_w'(1);
                w_addr_d = w_addr_q + c_addr_w'(1);
                if (k_q == c_k_last) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                for (int j = 0; j < N_OUT; j++) begin
                    acc_d[j] = acc_biased[j];
                end
                out_data_d  = y_flat;
                out_sat_d   = sat_flat;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            w_addr_q    <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            w_addr_q    <= w_addr_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    // in_ready is masked by reset so it never advertises acceptance mid-reset.
    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.w_addr    = w_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_layer_mac_sequencer
// Description : Directed, table-driven bench for the dense-layer MAC sequencer
//               with a 1-cycle-latency weight ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_layer_mac_sequencer;
    localparam int N_IN  = 32;
    localparam int N_OUT = 5;
    localparam int WIDTH = 15;
    localparam int NFRAC = 7;
    localparam int LAT   = N_IN + 3;

    typedef struct {
        bit                     rom127;
        int                     x0;
        int                     x1;
        int                     xmid;
        int                     xlast;
        logic [N_OUT*WIDTH-1:0] y;
        logic [N_OUT-1:0]       sat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rom_all127 = 1'b0;
    int   row0 [N_OUT] = '{-2, 40, 17, -6, -14};
    int   bvec [N_OUT] = '{-8, 5, -3, 10, 27};
    vec_t vecs [8];

    dense_layer_mac_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH)) bus ();

    dense_layer_mac_sequencer #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .WIDTH(WIDTH),
        .NFRAC(NFRAC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_OUT*WIDTH-1:0] pack5(input int a0, a1, a2, a3, a4);
        logic [N_OUT*WIDTH-1:0] r;
        r[0*WIDTH +: WIDTH] = WIDTH'(a0);
        r[1*WIDTH +: WIDTH] = WIDTH'(a1);
        r[2*WIDTH +: WIDTH] = WIDTH'(a2);
        r[3*WIDTH +: WIDTH] = WIDTH'(a3);
        r[4*WIDTH +: WIDTH] = WIDTH'(a4);
        return r;
    endfunction

    // Weight ROM: row 0 fixed, other rows a deterministic pattern in [-32,31].
    function automatic logic [N_OUT*WIDTH-1:0] rom_row(input int k);
        logic [N_OUT*WIDTH-1:0] r;
        int w;
        for (int j = 0; j < N_OUT; j++) begin
            if (rom_all127)  w = 127;
            else if (k == 0) w = row0[j];
            else             w = ((k*7 + j*13) % 64) - 32;
            r[j*WIDTH +: WIDTH] = WIDTH'(w);
        end
        return r;
    endfunction

    always @(posedge clk) bus.w_row <= rom_row(int'(bus.w_addr));

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            bus.bias[j*WIDTH +: WIDTH] = WIDTH'(bvec[j]);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_x(input int x0, input int x1, input int xmid, input int xlast);
        for (int k = 0; k < N_IN; k++) begin
            int v;
            v = (k == 0) ? x0 : (k == 1) ? x1 : (k == N_IN-1) ? xlast : xmid;
            bus.in_data[k*WIDTH +: WIDTH] = WIDTH'(v);
        end
    endtask

    // Entered and left at #1 after a rising edge; accept happens at the next edge.
    task automatic accept(input string name);
        bus.in_valid = 1'b1;
        chk({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_out(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, "_valid_drop"}, bus.out_valid, 0);
        chk({name, "_idle_busy"},  bus.busy, 0);
        chk({name, "_idle_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int   lat;
        bit   stable;
        bit   ready_low;
        bit   valid_high;
        bit   spurious;
        logic [N_OUT*WIDTH-1:0] held;

        vecs[0] = '{1'b0, 0,   0,    0, 0,   pack5(-8, 5, -3, 10, 27),   5'h00};
        vecs[1] = '{1'b0, 128, 0,    0, 0,   pack5(-10, 45, 14, 4, 13),  5'h00};
        vecs[2] = '{1'b0, 64,  64,   0, 0,   pack5(-21, 19, 6, 14, 34),  5'h00};
        vecs[3] = '{1'b0, 0,   -128, 0, 0,   pack5(17, 17, -4, -4, 0),   5'h00};
        vecs[4] = '{1'b0, 3,   0,    0, 0,   pack5(-8, 6, -3, 10, 27),   5'h00};
        vecs[5] = '{1'b0, 0,   0,    0, 128, pack5(-15, 11, 16, -22, 8), 5'h00};
        vecs[6] = '{1'b1, 16383, 16383, 16383, 16383,
                    pack5(16383, 16383, 16383, 16383, 16383), 5'h1F};
        vecs[7] = '{1'b1, -16384, -16384, -16384, -16384,
                    pack5(-16384, -16384, -16384, -16384, -16384), 5'h1F};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", bus.in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_out_data", bus.out_data, 0);
        chk("idle_out_sat", bus.out_sat, 0);
        chk("idle_w_addr", bus.w_addr, 0);

        for (int i = 0; i < 8; i++) begin
            rom_all127 = vecs[i].rom127;
            drive_x(vecs[i].x0, vecs[i].x1, vecs[i].xmid, vecs[i].xlast);
            accept($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_busy", i), bus.busy, 1);
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].y);
            chk($sformatf("vec%0d_out_sat", i), bus.out_sat, vecs[i].sat);
            chk($sformatf("vec%0d_in_ready_out", i), bus.in_ready, 0);
            finish_out($sformatf("vec%0d", i));
        end
        rom_all127 = 1'b0;

        // Back-pressure: result must hold while in_valid pulses are ignored.
        drive_x(128, 0, 0, 0);
        accept("bp");
        wait_out(lat);
        chk("bp_latency", lat, LAT);
        held       = bus.out_data;
        stable     = 1'b1;
        ready_low  = 1'b1;
        valid_high = 1'b1;
        bus.in_data = '1;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            @(posedge clk); #1;
            if (bus.out_data !== held) stable = 1'b0;
            if (bus.in_ready !== 1'b0) ready_low = 1'b0;
            if (bus.out_valid !== 1'b1) valid_high = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("bp_data_stable", stable, 1);
        chk("bp_in_ready_low", ready_low, 1);
        chk("bp_valid_held", valid_high, 1);
        chk("bp_out_data", bus.out_data, vecs[1].y);
        finish_out("bp");
        @(posedge clk); #1;
        chk("bp_no_spurious_start", bus.busy, 0);

        // Reset mid-MAC: abort cleanly, then a fresh vector gives the exact result.
        drive_x(127, 127, 127, 127);
        accept("rst");
        repeat (9) @(posedge clk);
        #1;
        chk("rst_busy_mid_mac", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy_cleared", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready_during", bus.in_ready, 0);
        chk("rst_w_addr", bus.w_addr, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_after", bus.in_ready, 1);
        spurious = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) spurious = 1'b1;
        end
        chk("rst_no_partial_result", spurious, 0);
        drive_x(128, 0, 0, 0);
        accept("rst_rerun");
        wait_out(lat);
        chk("rst_rerun_latency", lat, LAT);
        chk("rst_rerun_out_data", bus.out_data, vecs[1].y);
        chk("rst_rerun_out_sat", bus.out_sat, 0);
        finish_out("rst_rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
